// File: rtl/cnn_acc_pkg.sv
// Shared types, limits and fixed-point helpers for the CNN accumulator datapath.
package cnn_acc_pkg;

  localparam int unsigned PSUM_W_DEF = 18;
  localparam int unsigned ACC_W_DEF  = 26;
  // Working width for the post pipeline; must cover ACC_W+2 of any instance.
  localparam int unsigned WIDE_W     = 40;

  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } wb_state_t;

  typedef struct packed {
    logic signed [15:0] bias;
    logic        [4:0]  shift;
    logic               relu;
  } quant_cfg_t;

  // Round-half-up arithmetic right shift; shift of 0 passes the value through.
  function automatic logic signed [WIDE_W-1:0] round_shift(
    input logic signed [WIDE_W-1:0] x,
    input logic        [4:0]        sh
  );
    logic signed [WIDE_W-1:0] half;
    half = '0;
    if (sh == 5'd0) return x;
    half = WIDE_W'(1) << (sh - 5'd1);
    return (x + half) >>> sh;
  endfunction

  function automatic logic signed [7:0] sat_int8(input logic signed [WIDE_W-1:0] x);
    if (x > WIDE_W'(INT8_MAX)) return 8'(INT8_MAX);
    if (x < WIDE_W'(INT8_MIN)) return 8'(INT8_MIN);
    return x[7:0];
  endfunction

endpackage

// File: rtl/wb_quant.sv
// Two-stage post pipeline: bias add, then rounding shift, optional ReLU and int8 saturation.
module wb_quant
  import cnn_acc_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    acc_valid,
  input  logic signed [ACC_W-1:0] acc_final,
  input  quant_cfg_t              cfg,
  output logic                    stage1_valid,
  output logic                    res_valid,
  output logic signed [7:0]       res_data
);

  logic signed [ACC_W:0]      s1;
  logic signed [15:0]         bias_c;
  logic signed [WIDE_W-1:0]   r_c;

  assign bias_c = cfg.bias;

  always_comb begin
    r_c = round_shift(WIDE_W'(s1), cfg.shift);
    if (cfg.relu && r_c[WIDE_W-1]) r_c = '0;
  end

  // Stage 1 registers the biased sum; stage 2 registers the quantised result.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage1_valid <= 1'b0;
      s1           <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
    end else begin
      stage1_valid <= acc_valid;
      if (acc_valid) s1 <= (ACC_W+1)'(acc_final) + (ACC_W+1)'(bias_c);
      res_valid <= stage1_valid;
      if (stage1_valid) res_data <= sat_int8(r_c);
    end
  end

endmodule

// File: rtl/psum_writeback.sv
// Accumulates PE-group sums per output pixel, quantises each pixel and writes it to the ofmap buffer.
module psum_writeback
  import cnn_acc_pkg::*;
#(
  parameter int unsigned PSUM_W = PSUM_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_start,
  input  logic        [CNT_W-1:0]  cfg_acc_len,
  input  logic        [ADDR_W-1:0] cfg_out_num,
  input  logic        [ADDR_W-1:0] cfg_base_addr,
  input  logic signed [15:0]       cfg_bias,
  input  logic        [4:0]        cfg_shift,
  input  logic                     cfg_relu,
  input  logic                     psum_valid,
  input  logic signed [PSUM_W-1:0] psum_in,
  output logic                     wr_en,
  output logic        [ADDR_W-1:0] wr_addr,
  output logic signed [7:0]        wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     ovf
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  wb_state_t               state;
  logic [CNT_W-1:0]        acc_len_m1;
  logic [ADDR_W-1:0]       out_num_m1;
  logic [ADDR_W-1:0]       base_addr;
  quant_cfg_t              qcfg;
  logic [CNT_W-1:0]        cnt;
  logic [ADDR_W-1:0]       pix_in;
  logic [ADDR_W-1:0]       pix_idx;
  logic signed [ACC_W-1:0] acc;
  logic                    stage1_valid;

  logic                    take_c;
  logic                    final_c;
  logic                    last_c;
  logic                    acc_sat_c;
  logic signed [ACC_W-1:0] addend_c;
  logic signed [ACC_W:0]   acc_sum_c;
  logic signed [ACC_W-1:0] acc_next_c;

  // One extra bit of headroom exposes overflow as a mismatch of the top two bits.
  always_comb begin
    take_c     = (state == RUN) && psum_valid;
    addend_c   = (cnt == '0) ? '0 : acc;
    acc_sum_c  = (ACC_W+1)'(addend_c) + (ACC_W+1)'(psum_in);
    acc_sat_c  = acc_sum_c[ACC_W] != acc_sum_c[ACC_W-1];
    acc_next_c = acc_sum_c[ACC_W-1:0];
    if (acc_sat_c) acc_next_c = acc_sum_c[ACC_W] ? ACC_MIN : ACC_MAX;
    final_c    = take_c && (cnt == acc_len_m1);
    last_c     = final_c && (pix_in == out_num_m1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc_len_m1 <= '0;
      out_num_m1 <= '0;
      base_addr  <= '0;
      qcfg       <= '0;
      cnt        <= '0;
      pix_in     <= '0;
      pix_idx    <= '0;
      acc        <= '0;
      wr_addr    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            acc_len_m1 <= (cfg_acc_len == '0) ? '0 : cfg_acc_len - CNT_W'(1);
            out_num_m1 <= cfg_out_num - ADDR_W'(1);
            base_addr  <= cfg_base_addr;
            qcfg       <= '{bias: cfg_bias, shift: cfg_shift, relu: cfg_relu};
            cnt        <= '0;
            pix_in     <= '0;
            pix_idx    <= '0;
            ovf        <= 1'b0;
            if (cfg_out_num == '0) begin
              done <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (take_c) begin
            acc <= acc_next_c;
            if (acc_sat_c) ovf <= 1'b1;
            if (final_c) begin
              cnt    <= '0;
              pix_in <= pix_in + ADDR_W'(1);
              if (last_c) state <= DRAIN;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          // Stage 2 empties on this edge when stage 1 holds nothing.
          if (!stage1_valid) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // Address is registered alongside the stage-2 result it belongs to.
      if (stage1_valid) begin
        wr_addr <= base_addr + pix_idx;
        pix_idx <= pix_idx + ADDR_W'(1);
      end
    end
  end

  wb_quant #(
    .ACC_W(ACC_W)
  ) u_quant (
    .clk         (clk),
    .rst         (rst),
    .acc_valid   (final_c),
    .acc_final   (acc_next_c),
    .cfg         (qcfg),
    .stage1_valid(stage1_valid),
    .res_valid   (wr_en),
    .res_data    (wr_data)
  );

endmodule

// File: tb/tb_psum_writeback.sv
// Directed bench for psum_writeback: a 26-bit accumulator instance plus an 18-bit one for overflow.
module tb_psum_writeback;

  logic               clk;
  logic               rst;
  logic               cfg_start;
  logic [7:0]         cfg_acc_len;
  logic [9:0]         cfg_out_num;
  logic [9:0]         cfg_base_addr;
  logic signed [15:0] cfg_bias;
  logic [4:0]         cfg_shift;
  logic               cfg_relu;
  logic               psum_valid;
  logic signed [17:0] psum_in;

  logic               wr_en, busy, done, ovf;
  logic [9:0]         wr_addr;
  logic signed [7:0]  wr_data;
  logic               wr_en18, busy18, done18, ovf18;
  logic [9:0]         wr_addr18;
  logic signed [7:0]  wr_data18;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int wr_cnt18 = 0;
  int snap, snap18;
  logic seen;

  psum_writeback #(.PSUM_W(18), .ACC_W(26), .ADDR_W(10), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_acc_len(cfg_acc_len),
    .cfg_out_num(cfg_out_num), .cfg_base_addr(cfg_base_addr), .cfg_bias(cfg_bias),
    .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .psum_valid(psum_valid), .psum_in(psum_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .ovf(ovf)
  );

  psum_writeback #(.PSUM_W(18), .ACC_W(18), .ADDR_W(10), .CNT_W(8)) dut18 (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_acc_len(cfg_acc_len),
    .cfg_out_num(cfg_out_num), .cfg_base_addr(cfg_base_addr), .cfg_bias(cfg_bias),
    .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .psum_valid(psum_valid), .psum_in(psum_in),
    .wr_en(wr_en18), .wr_addr(wr_addr18), .wr_data(wr_data18), .busy(busy18), .done(done18),
    .ovf(ovf18)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) wr_cnt++;
    if (wr_en18) wr_cnt18++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic start(input int len, input int num, input int base, input int bias,
                       input int sh, input logic relu);
    cfg_acc_len   = 8'(len);
    cfg_out_num   = 10'(num);
    cfg_base_addr = 10'(base);
    cfg_bias      = 16'(bias);
    cfg_shift     = 5'(sh);
    cfg_relu      = relu;
    cfg_start     = 1'b1;
    tick();
    cfg_start     = 1'b0;
  endtask

  task automatic send(input int v);
    psum_valid = 1'b1;
    psum_in    = 18'(v);
    tick();
    psum_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_acc_len = '0; cfg_out_num = '0; cfg_base_addr = '0;
    cfg_bias = '0; cfg_shift = '0; cfg_relu = 1'b0; psum_valid = 1'b0; psum_in = '0;
    tick(); tick(); tick();
    rst = 1'b0;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovf", 32'(ovf), 0);

    // acc_len=5, saturating 150 to 127
    start(5, 1, 100, 0, 0, 1'b0);
    chk("t1_busy", 32'(busy), 1);
    send(10); send(20); send(30); send(40); send(50);
    chk("t1_no_wr_yet", 32'(wr_en), 0);
    tick();
    chk("t1_wr_en", 32'(wr_en), 1);
    chk("t1_wr_data", wr_data, 127);
    chk("t1_wr_addr", 32'(wr_addr), 100);
    chk("t1_done_early", 32'(done), 0);
    tick();
    chk("t1_done", 32'(done), 1);
    chk("t1_wr_off", 32'(wr_en), 0);
    chk("t1_hold_data", wr_data, 127);
    chk("t1_busy_off", 32'(busy), 0);
    tick();
    chk("t1_done_pulse", 32'(done), 0);

    // bias 8 and rounding shift 4: (88+8)>>>4 = 6
    start(3, 1, 200, 8, 4, 1'b0);
    send(100); send(-20); send(0);
    tick();
    chk("t2_wr_en", 32'(wr_en), 1);
    chk("t2_wr_data", wr_data, 6);
    chk("t2_wr_addr", 32'(wr_addr), 200);
    tick();
    chk("t2_done", 32'(done), 1);

    // ReLU, acc_len=1, addresses wrap past 1023
    start(1, 3, 1022, 0, 0, 1'b1);
    send(-5);
    send(7);
    chk("t3_wr0_en", 32'(wr_en), 1);
    chk("t3_wr0_data", wr_data, 0);
    chk("t3_wr0_addr", 32'(wr_addr), 1022);
    send(-300);
    chk("t3_wr1_en", 32'(wr_en), 1);
    chk("t3_wr1_data", wr_data, 7);
    chk("t3_wr1_addr", 32'(wr_addr), 1023);
    tick();
    chk("t3_wr2_en", 32'(wr_en), 1);
    chk("t3_wr2_data", wr_data, 0);
    chk("t3_wr2_addr", 32'(wr_addr), 0);
    tick();
    chk("t3_done", 32'(done), 1);

    // negative rounding and low saturation
    start(1, 2, 5, 0, 1, 1'b0);
    send(-3);
    send(-1000);
    chk("t4_wr0_data", wr_data, -1);
    chk("t4_wr0_addr", 32'(wr_addr), 5);
    tick();
    chk("t4_wr1_data", wr_data, -128);
    chk("t4_wr1_addr", 32'(wr_addr), 6);
    tick();
    chk("t4_done", 32'(done), 1);

    // 256 pixels of 2 x 131071: fits 26 bits, saturates the 18-bit instance
    snap = wr_cnt; snap18 = wr_cnt18;
    start(2, 256, 0, 0, 0, 1'b0);
    for (int i = 0; i < 512; i++) send(131071);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk("t5_done_seen", 32'(seen), 1);
    chk("t5_done18", 32'(done18), 1);
    chk("t5_wr_count", wr_cnt - snap, 256);
    chk("t5_wr_count18", wr_cnt18 - snap18, 256);
    chk("t5_last_addr", 32'(wr_addr), 255);
    chk("t5_last_data", wr_data, 127);
    chk("t5_last_data18", wr_data18, 127);
    chk("t5_ovf26", 32'(ovf), 0);
    chk("t5_ovf18", 32'(ovf18), 1);
    tick(); tick(); tick();
    chk("t5_ovf18_sticky", 32'(ovf18), 1);
    chk("t5_busy18_off", 32'(busy18), 0);

    // out_num=0: immediate done, no write, and cfg_start clears ovf
    snap = wr_cnt;
    start(1, 0, 0, 0, 0, 1'b0);
    chk("t6_done", 32'(done), 1);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_ovf18_clr", 32'(ovf18), 0);
    tick();
    chk("t6_done_pulse", 32'(done), 0);
    tick();
    chk("t6_no_write", wr_cnt - snap, 0);

    // reset mid-layer discards the partial pixel; stray psum while idle is ignored
    snap = wr_cnt;
    start(5, 1, 50, 0, 0, 1'b0);
    send(1); send(1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_rst_busy", 32'(busy), 0);
    send(9);
    tick(); tick(); tick(); tick();
    chk("t7_no_stray", wr_cnt - snap, 0);
    start(5, 1, 50, 0, 0, 1'b0);
    send(1);
    cfg_base_addr = 10'd900;
    cfg_start = 1'b1;
    send(1);
    cfg_start = 1'b0;
    send(1); send(1); send(1);
    tick();
    chk("t7_wr_en", 32'(wr_en), 1);
    chk("t7_wr_data", wr_data, 5);
    chk("t7_wr_addr", 32'(wr_addr), 50);
    tick();
    chk("t7_done", 32'(done), 1);
    chk("t7_single_write", wr_cnt - snap, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
